lsu_master: RTL
===============

Name: lsu_master

Overview:
- Load/store initiator that drives the data-memory port of the memory system: word address, write data, write enable. Read data returns combinationally on the same port.
- Accepts one byte, halfword or word request at a time from the datapath and returns one response.
- Byte and halfword stores are done as read-modify-write, because memory writes whole words only.
- Rejects misaligned accesses and stores into the ROM region before any memory traffic is issued.

Parameters:
DATA_WIDTH, 32, data and address width; only 32 is supported.
RAM_BASE, 32'h1000_0000, lowest writable address; addresses below it are ROM.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_valid_i  input  1  request present
req_ready_o  output  1  block can accept a request this cycle
req_write_i  input  1  1 = store, 0 = load
req_size_i  input  2  00 byte, 01 half, 10 word; 11 is treated as word
req_signed_i  input  1  loads: sign-extend (1) or zero-extend (0)
req_addr_i  input  DATA_WIDTH  byte address
req_wdata_i  input  DATA_WIDTH  store data, right-aligned
resp_valid_o  output  1  one-cycle response pulse
resp_rdata_o  output  DATA_WIDTH  load result, extended; 0 for stores and errors
resp_err_o  output  1  qualifies resp_valid_o: misaligned access or store below RAM_BASE
mem_address_o  output  DATA_WIDTH  word-aligned address, {addr[31:2],2'b00}
mem_write_data_o  output  DATA_WIDTH  word to write
mem_write_enable_o  output  1  write strobe
mem_read_data_i  input  DATA_WIDTH  combinational read data for mem_address_o

Behaviour:
- State machine states: IDLE, READ, WRITE, RESP, ERR.
- Reset values: state IDLE; req_ready_o=1; resp_valid_o=0; resp_err_o=0; resp_rdata_o=0; mem_write_enable_o=0; mem_address_o=0; mem_write_data_o=0; all request latches 0.
- IDLE:
  - req_ready_o=1. A request is accepted when req_valid_i=1 in IDLE; all request fields are latched on that edge.
  - Misaligned means half with addr[0]=1, or word with addr[1:0]!=0. Misaligned, or store with addr < RAM_BASE → ERR.
  - Otherwise a load, sub-word store or word store → READ, READ or WRITE respectively.
- READ: drive mem_address_o. Capture mem_read_data_i into old_word at the end of the cycle. A load then goes to RESP; a store goes to WRITE.
- WRITE: drive mem_address_o and mem_write_data_o, with mem_write_enable_o=1 for exactly this one cycle → RESP.
  - Word store: data = wdata.
  - Half store: old_word with lane addr[1]*16 replaced by wdata[15:0].
  - Byte store: old_word with lane addr[1:0]*8 replaced by wdata[7:0].
- RESP: resp_valid_o=1, resp_err_o=0 → IDLE. resp_rdata_o for loads:
  - Lanes are little-endian; byte k is bits 8k+7:8k.
  - The selected byte or half is extended per req_signed_i; a word is passed unchanged.
- ERR: resp_valid_o=1, resp_err_o=1, resp_rdata_o=0, no memory write → IDLE.
- Latency, counting the acceptance cycle as N:
  - load, resp at N+2
  - word store, resp at N+2
  - sub-word store, resp at N+3
  - error, resp at N+1
- req_ready_o=0 outside IDLE; req_valid_i is ignored then. The next request is acceptable in the cycle after resp_valid_o.
- No response backpressure; resp_valid_o is a single-cycle pulse.
- mem_address_o and mem_write_data_o are 0 in IDLE, RESP and ERR. mem_write_enable_o is 0 outside WRITE.
- Reset mid-operation:
  - mem_write_enable_o = (state==WRITE) & ~reset, so no write lands in a reset cycle.
  - The next state is IDLE; no response is produced for the aborted request.
- Store data merge uses only the captured old_word, never a live read in WRITE.

Decomposition:
- Package lsu_pkg contains:
  - size enum: SZ_BYTE, SZ_HALF, SZ_WORD
  - state enum
  - RAM_BASE default constant
  - function misaligned(size, addr)
- Sub-module byte_lane_unit (combinational) contains:
  - load extraction and extension (old_word, addr[1:0], size, signed → rdata)
  - store merge (old_word, wdata, addr[1:0], size → new_word)

Test Plan:
1. Memory[0x1000_0000]=0x8899AABB. Signed byte load at 0x1000_0001 → resp at N+2, rdata=0xFFFFFFAA, err=0. Unsigned byte load → 0x000000AA.
2. Same word, store half 0x1234 at 0x1000_0002 → READ then WRITE. mem_write_data_o=0x1234AABB, WE high exactly 1 cycle, resp at N+3.
3. Word store 0xDEADBEEF at 0x1000_0004 → no READ, WE at N+1, resp at N+2. A following word load returns 0xDEADBEEF.
4. Word load at 0x1000_0002 → resp_err=1 at N+1, rdata=0, WE never asserted. Half load at 0x1000_0003 also errors.
5. Byte store to 0x0000_0040 (ROM region) → err at N+1, no WE. Byte load at 0x0000_0040 succeeds with ROM data.
6. reset asserted in the WRITE cycle of a byte store → WE=0 that cycle, memory unchanged, no resp, req_ready_o=1 next cycle. req_valid_i held high throughout a busy op → only one accept.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store initiator.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESP,
    S_ERR
  } state_e;

  localparam logic [31:0] RAM_BASE_DEFAULT = 32'h1000_0000;

  // Encoding 2'b11 is folded into a word access.
  function automatic size_e to_size(input logic [1:0] raw);
    case (raw)
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic misaligned(input size_e size, input logic [1:0] addr_lo);
    case (size)
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_master_byte_lane_unit.sv
// Little-endian lane extraction for loads and read-modify-write merge for stores.
module byte_lane_unit
  import lsu_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  addr_lo,
  input  size_e       size,
  input  logic        sign,
  output logic [31:0] rdata,
  output logic [31:0] new_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = old_word[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? old_word[31:16] : old_word[15:0];

    case (size)
      SZ_BYTE: rdata = {{24{sign & byte_sel[7]}}, byte_sel};
      SZ_HALF: rdata = {{16{sign & half_sel[15]}}, half_sel};
      default: rdata = old_word;
    endcase

    new_word = old_word;
    case (size)
      SZ_BYTE: new_word[{addr_lo, 3'b000} +: 8]         = wdata[7:0];
      SZ_HALF: new_word[{addr_lo[1], 4'b0000} +: 16]    = wdata[15:0];
      default: new_word                                  = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_master.sv
// Single-outstanding load/store initiator driving a word-wide memory port;
// sub-word stores are done as read-modify-write.
module lsu_master
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] RAM_BASE   = RAM_BASE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_signed_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o,
  output logic [DATA_WIDTH-1:0] mem_address_o,
  output logic [DATA_WIDTH-1:0] mem_write_data_o,
  output logic                  mem_write_enable_o,
  input  logic [DATA_WIDTH-1:0] mem_read_data_i
);

  state_e                state, state_next;
  logic                  write_q;
  size_e                 size_q;
  logic                  signed_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] merged_word;
  logic                  write_strobe;
  size_e                 req_size;

  assign req_size = to_size(req_size_i);

  byte_lane_unit u_lanes (
    .old_word (old_word),
    .wdata    (wdata_q),
    .addr_lo  (addr_q[1:0]),
    .size     (size_q),
    .sign     (signed_q),
    .rdata    (load_data),
    .new_word (merged_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      write_q  <= 1'b0;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      old_word <= '0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && req_valid_i) begin
        write_q  <= req_write_i;
        size_q   <= req_size;
        signed_q <= req_signed_i;
        addr_q   <= req_addr_i;
        wdata_q  <= req_wdata_i;
      end
      if (state == S_READ) old_word <= mem_read_data_i;
    end
  end

  always_comb begin
    state_next       = state;
    req_ready_o      = 1'b0;
    resp_valid_o     = 1'b0;
    resp_err_o       = 1'b0;
    resp_rdata_o     = '0;
    mem_address_o    = '0;
    mem_write_data_o = '0;
    write_strobe     = 1'b0;

    case (state)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          if (misaligned(req_size, req_addr_i[1:0]) || (req_write_i && req_addr_i < RAM_BASE))
            state_next = S_ERR;
          else if (!req_write_i)
            state_next = S_READ;
          else if (req_size == SZ_WORD)
            state_next = S_WRITE;
          else
            state_next = S_READ;
        end
      end
      S_READ: begin
        mem_address_o = {addr_q[DATA_WIDTH-1:2], 2'b00};
        state_next    = write_q ? S_WRITE : S_RESP;
      end
      S_WRITE: begin
        // Merge uses the word captured in READ; a word store bypasses it entirely.
        mem_address_o    = {addr_q[DATA_WIDTH-1:2], 2'b00};
        mem_write_data_o = merged_word;
        write_strobe     = 1'b1;
        state_next       = S_RESP;
      end
      S_RESP: begin
        resp_valid_o = 1'b1;
        resp_rdata_o = write_q ? '0 : load_data;
        state_next   = S_IDLE;
      end
      S_ERR: begin
        resp_valid_o = 1'b1;
        resp_err_o   = 1'b1;
        state_next   = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Gate with reset so an aborted store never lands.
  assign mem_write_enable_o = write_strobe & ~reset;

endmodule
